// File: rtl/shifter_pkg.sv
// Shared types, default width and golden shift model for the ALU shifter.
// The rotate option is controlled by the SHIFTER_ROR_EN macro in the design files.
package shifter_pkg;

    localparam int SHIFT_W = 16;

    typedef enum logic {
        SHIFT_SLL = 1'b0,
        SHIFT_SRA = 1'b1
    } shift_mode_e;

    // Behavioural reference; the datapath never uses these operators.
    function automatic logic [SHIFT_W-1:0] shift_ref(
        input logic [SHIFT_W-1:0]         data,
        input logic [$clog2(SHIFT_W)-1:0] amt,
        input shift_mode_e                mode
    );
        logic signed [SHIFT_W-1:0] sdata;
        sdata = $signed(data);
        if (mode == SHIFT_SRA)
            shift_ref = sdata >>> amt;
        else
            shift_ref = data << amt;
    endfunction

endpackage

// File: rtl/shifter_unit_stage.sv
// One log-shifter stage: shifts by the fixed distance DIST when en is set.
// With SHIFTER_ROR_EN defined, a rot input selects rotate-right over mode.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = SHIFT_W,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  logic             mode,
`ifdef SHIFTER_ROR_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] sll_d;
    logic [WIDTH-1:0] sra_d;

    assign sll_d = {data[WIDTH-DIST-1:0], {DIST{1'b0}}};
    assign sra_d = {{DIST{data[WIDTH-1]}}, data[WIDTH-1:DIST]};

`ifdef SHIFTER_ROR_EN
    logic [WIDTH-1:0] ror_d;
    assign ror_d = {data[DIST-1:0], data[WIDTH-1:DIST]};
`endif

    always_comb begin
        result = data;
        if (en) begin
            if (shift_mode_e'(mode) == SHIFT_SRA)
                result = sra_d;
            else
                result = sll_d;
`ifdef SHIFTER_ROR_EN
            if (rot)
                result = ror_d;
`endif
        end
    end

endmodule

// File: rtl/shifter_unit.sv
// Registered 16-bit barrel shifter (SLL / SRA) built as a cascade of log stages.
// Defining SHIFTER_ROR_EN adds the Rot port and rotate-right support.
module shifter_unit
    import shifter_pkg::*;
#(
    parameter int WIDTH = SHIFT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         Shift_In,
    input  logic [$clog2(WIDTH)-1:0] Shift_Val,
    input  logic                     Mode,
`ifdef SHIFTER_ROR_EN
    input  logic                     Rot,
`endif
    output logic [WIDTH-1:0]         Shift_Out
);

    localparam int AW = $clog2(WIDTH);

    // stage_d[k] feeds stage k; stage_d[AW] is the fully shifted value
    logic [WIDTH-1:0] stage_d [0:AW];

    assign stage_d[0] = Shift_In;

    for (genvar k = 0; k < AW; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_stage (
            .data   (stage_d[k]),
            .en     (Shift_Val[k]),
            .mode   (Mode),
`ifdef SHIFTER_ROR_EN
            .rot    (Rot),
`endif
            .result (stage_d[k+1])
        );
    end

    // ---- stage p0: output register ----
    always_ff @(posedge clk) begin
        if (rst)
            Shift_Out <= '0;
        else
            Shift_Out <= stage_d[AW];
    end

endmodule

// File: tb/tb_shifter_unit.sv
// Scoreboard bench for shifter_unit: driver pushes expected results, monitor checks one cycle later.
// Rotate vectors are exercised when SHIFTER_ROR_EN is defined.
module tb_shifter_unit;

    localparam int W  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  shift_in = '0;
    logic [AW-1:0] shift_val = '0;
    logic          mode = 1'b0;
`ifdef SHIFTER_ROR_EN
    logic          rot = 1'b0;
`endif
    logic [W-1:0]  shift_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] exp;
        string        name;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    shifter_unit dut (
        .clk       (clk),
        .rst       (rst),
        .Shift_In  (shift_in),
        .Shift_Val (shift_val),
        .Mode      (mode),
`ifdef SHIFTER_ROR_EN
        .Rot       (rot),
`endif
        .Shift_Out (shift_out)
    );

    function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [AW-1:0] a,
                                           input logic m, input logic r);
        logic [2*W-1:0] dd;
        logic signed [W-1:0] sd;
        if (r) begin
            dd = {d, d} >> a;
            return dd[W-1:0];
        end
        if (m) begin
            sd = $signed(d);
            return sd >>> a;
        end
        return d << a;
    endfunction

    // Apply one operation before the next rising edge and queue its expected result
    task automatic issue(input logic r_st, input logic [W-1:0] d, input logic [AW-1:0] a,
                         input logic m, input logic r, input logic [W-1:0] exp, input string name);
        @(negedge clk);
        rst       = r_st;
        shift_in  = d;
        shift_val = a;
        mode      = m;
`ifdef SHIFTER_ROR_EN
        rot       = r;
`endif
        sb_q.push_back('{exp: exp, name: name});
    endtask

    // Monitor: one result is due one edge after each issue
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            total++;
            if (shift_out !== e.exp) begin
                bad++;
                $display("FAIL %s: got 0x%04h expected 0x%04h", e.name, shift_out, e.exp);
            end
        end
    end

    logic [W-1:0] ops [0:15];

    initial begin
        ops[0] = 16'h0000; ops[1] = 16'hFFFF; ops[2] = 16'h8000; ops[3] = 16'h0001;
        ops[4] = 16'h7FFF; ops[5] = 16'hAAAA; ops[6] = 16'h5555; ops[7] = 16'h8001;
        for (int i = 8; i < 16; i++) ops[i] = W'($urandom);

        // reset with all-ones input present
        issue(1'b1, 16'hFFFF, 4'd0, 1'b0, 1'b0, 16'h0000, "reset_c0");
        issue(1'b1, 16'hFFFF, 4'd3, 1'b1, 1'b0, 16'h0000, "reset_c1");
        issue(1'b0, 16'h0001, 4'd4, 1'b0, 1'b0, 16'h0010, "sll_1_by_4");

        issue(1'b0, 16'h8000, 4'd15, 1'b1, 1'b0, 16'hFFFF, "sra_8000_by_15");
        issue(1'b0, 16'h7FF0, 4'd4,  1'b1, 1'b0, 16'h07FF, "sra_7ff0_by_4");
        issue(1'b0, 16'hF00F, 4'd0,  1'b1, 1'b0, 16'hF00F, "sra_f00f_by_0");
        issue(1'b0, 16'hF00F, 4'd0,  1'b0, 1'b0, 16'hF00F, "sll_f00f_by_0");
        issue(1'b0, 16'h7FFF, 4'd15, 1'b1, 1'b0, 16'h0000, "sra_7fff_by_15");

        issue(1'b0, 16'hFFFF, 4'd15, 1'b0, 1'b0, 16'h8000, "sll_ffff_by_15");
        issue(1'b0, 16'h1234, 4'd8,  1'b0, 1'b0, 16'h3400, "sll_1234_by_8");

        issue(1'b0, 16'h0003, 4'd1, 1'b0, 1'b0, 16'h0006, "b2b_sll");
        issue(1'b0, 16'h8001, 4'd1, 1'b1, 1'b0, 16'hC000, "b2b_sra");
        issue(1'b0, 16'h0003, 4'd1, 1'b0, 1'b0, 16'h0006, "b2b_sll_rst");
        issue(1'b1, 16'h8001, 4'd1, 1'b1, 1'b0, 16'h0000, "b2b_sra_rst");
        issue(1'b0, 16'h8001, 4'd1, 1'b1, 1'b0, 16'hC000, "after_rst");

`ifdef SHIFTER_ROR_EN
        issue(1'b0, 16'h0001, 4'd1, 1'b0, 1'b1, 16'h8000, "ror_1_by_1");
        issue(1'b0, 16'h1234, 4'd4, 1'b0, 1'b1, 16'h4123, "ror_1234_by_4");
        issue(1'b0, 16'h1234, 4'd4, 1'b1, 1'b1, 16'h4123, "ror_mode1");
        issue(1'b0, 16'h8001, 4'd0, 1'b1, 1'b1, 16'h8001, "ror_by_0");
`endif

        // sampled sweep: every amount and mode over a set of operands
        for (int i = 0; i < 16; i++)
            for (int a = 0; a < 16; a++)
                for (int m = 0; m < 2; m++)
                    issue(1'b0, ops[i], AW'(a), m[0], 1'b0,
                          model(ops[i], AW'(a), m[0], 1'b0), "sweep");

`ifdef SHIFTER_ROR_EN
        for (int i = 0; i < 16; i++)
            for (int a = 0; a < 16; a++)
                issue(1'b0, ops[i], AW'(a), i[0], 1'b1,
                      model(ops[i], AW'(a), 1'b0, 1'b1), "sweep_ror");
`endif

        repeat (3) @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d results still pending, expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
